ddr_cmd_sequencer: RTL and testbench
====================================

Name: ddr_cmd_sequencer

Overview:
- Upstream command stage for the DDR4 DIMM model: converts controller read/write requests into single-cycle DDR4 command/address patterns on the ddr_interface pins (ACT, RD, WR, PRE, PREA, REF, deselect).
- Tracks one open row per bank (4 bank groups x 4 banks) and sequences PRE/ACT/CAS under tRP/tRCD/tCCD/tRFC counters.
- Serves refresh requests, closing all open banks first.

Parameters:
- T_RCD, 4, cycles from ACT to RD/WR on the same bank.
- T_RP, 4, cycles from PRE/PREA to the next ACT or REF.
- T_CCD, 4, cycles from RD/WR to the next accepted request.
- T_RFC, 20, cycles from REF to the next command.

Ports:
- CK_t  in  1  command clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_wr  in  1  1 = write, 0 = read.
- req_bg  in  2  bank group.
- req_ba  in  2  bank address.
- req_row  in  14  row address.
- req_col  in  10  column address.
- ref_req  in  1  level refresh request; held until ref_ack.
- ref_ack  out  1  one-cycle pulse in the REF command cycle.
- cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14  out  1 each  command pins.
- A13, A12_BC_n, A11, A10_AP  out  1 each  address pins.
- A9_A0  out  10  address pins.
- bg_addr  out  2  bank group pins.
- ba_addr  out  2  bank pins.
- cas_pulse  out  1  one-cycle pulse in a RD/WR command cycle.
- cas_wr  out  1  valid with cas_pulse; 1 = write.

Behaviour:
- Reset values: all command pins 1 (deselect); address pins, bg_addr and ba_addr 0; req_ready, ref_ack and cas_pulse 0; bank table all closed; state IDLE. An asserted reset mid-sequence aborts immediately; nothing is replayed.
- Pin encodings, {cs_n, act_n, RAS, CAS, WE}:
  - ACT = 00111; A13..A0 = row.
  - WR = 01100; RD = 01101; A9_A0 = col, A10_AP = 0, A12_BC_n = 1.
  - PRE = 01010 with A10_AP = 0.
  - PREA = 01010 with A10_AP = 1.
  - REF = 01001.
  - Idle cycles = 11111.
- Every command lasts exactly one cycle, registered on CK_t rise. bg_addr and ba_addr carry the target bank for ACT, PRE and CAS.
- req_ready = (state == IDLE) && !ref_req. The request is latched on acceptance.
- States: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, WAIT_CCD, PREA, WAIT_RPA, REF, WAIT_RFC.
- Transitions from IDLE: ref_req takes priority over req_valid in the same cycle.
  - Any bank open: go to PREA. None open: go to REF.
  - Accepted request, bank open on the same row (hit): go to CAS.
  - Bank closed: go to ACT.
  - Bank open on a different row (miss): go to PRE.
- Wait rules: for a T-cycle wait, the following command is driven exactly T cycles after the previous command cycle. A down-counter loaded with T-1 in the command cycle handles this; each WAIT state exits when the counter reaches 0.
- Transitions out of the wait states:
  - PRE, then WAIT_RP(T_RP), then ACT.
  - ACT, then WAIT_RCD(T_RCD), then CAS.
  - CAS, then WAIT_CCD(T_CCD), then IDLE.
  - PREA, then WAIT_RPA(T_RP), then REF.
  - REF, then WAIT_RFC(T_RFC), then IDLE.
- Latency, with acceptance at cycle 0:
  - Hit: CAS at cycle 1.
  - Closed bank: ACT at 1, CAS at 1+T_RCD.
  - Miss: PRE at 1, ACT at 1+T_RP, CAS at 1+T_RP+T_RCD.
  - In all cases req_ready is high again at CAS+T_CCD if ref_req is low.
- Bank table: ACT sets {open, row} for its bank; PRE clears its bank; PREA clears all 16 entries; REF changes nothing. Banks stay open after CAS (open-page policy).
- ref_req rising during a request sequence is deferred until IDLE; the in-flight request always completes.
- The timing counters use full-width decrement with no wrap. Parameters below 1 are illegal.

Test Plan:
- Reset, then write bg=1 ba=2 row=0x1A5 col=0x040 to a closed bank -> ACT (00111, A13..A0=0x1A5, bg=1, ba=2) at cycle 1; WR (01100, A9_A0=0x040) at cycle 5; cas_pulse=1 and cas_wr=1 at cycle 5; req_ready high at cycle 9.
- Read, same bank and row, col=0x080 -> RD (01101, A9_A0=0x080) at cycle 1 after acceptance; no ACT.
- Read, same bank, row=0x2B0 -> PRE (01010, A10_AP=0) at cycle 1; ACT row 0x2B0 at cycle 5; RD at cycle 9.
- ref_req asserted with two banks open -> req_ready=0; PREA (A10_AP=1) next cycle; REF and ref_ack 4 cycles later; req_ready high 20 cycles after REF with all banks closed.
- ref_req and req_valid asserted in the same IDLE cycle -> refresh is served first and the request is accepted only after WAIT_RFC.
- reset_n dropped during WAIT_RCD -> pins go to 11111 immediately; after release, the same request to that bank issues ACT again.

Source files
------------

// File: rtl/ddr_cmd_sequencer.sv
// DDR4 command sequencer: turns read/write/refresh requests into one-cycle command pin patterns,
// tracking the open row of each of the 16 banks and pacing commands with tRP/tRCD/tCCD/tRFC.
module ddr_cmd_sequencer #(
   parameter int unsigned T_RCD = 4,
   parameter int unsigned T_RP  = 4,
   parameter int unsigned T_CCD = 4,
   parameter int unsigned T_RFC = 20
) (
   input  logic        CK_t,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [1:0]  req_bg,
   input  logic [1:0]  req_ba,
   input  logic [13:0] req_row,
   input  logic [9:0]  req_col,
   input  logic        ref_req,
   output logic        ref_ack,
   output logic        cs_n,
   output logic        act_n,
   output logic        RAS_n_A16,
   output logic        CAS_n_A15,
   output logic        WE_n_A14,
   output logic        A13,
   output logic        A12_BC_n,
   output logic        A11,
   output logic        A10_AP,
   output logic [9:0]  A9_A0,
   output logic [1:0]  bg_addr,
   output logic [1:0]  ba_addr,
   output logic        cas_pulse,
   output logic        cas_wr
);

   localparam int unsigned TMaxA = (T_RCD > T_RP) ? T_RCD : T_RP;
   localparam int unsigned TMaxB = (T_CCD > T_RFC) ? T_CCD : T_RFC;
   localparam int unsigned TMax  = (TMaxA > TMaxB) ? TMaxA : TMaxB;
   localparam int unsigned CntW  = $clog2(TMax + 1);

   localparam logic [CntW-1:0] LdRcd = CntW'(T_RCD - 1);
   localparam logic [CntW-1:0] LdRp  = CntW'(T_RP - 1);
   localparam logic [CntW-1:0] LdCcd = CntW'(T_CCD - 1);
   localparam logic [CntW-1:0] LdRfc = CntW'(T_RFC - 1);

   // {cs_n, act_n, RAS_n, CAS_n, WE_n}
   localparam logic [4:0] CmdDes = 5'b11111;
   localparam logic [4:0] CmdAct = 5'b00111;
   localparam logic [4:0] CmdWr  = 5'b01100;
   localparam logic [4:0] CmdRd  = 5'b01101;
   localparam logic [4:0] CmdPre = 5'b01010;
   localparam logic [4:0] CmdRef = 5'b01001;

   typedef enum logic [3:0] {
      StIdle,
      StPre,
      StWaitRp,
      StAct,
      StWaitRcd,
      StCas,
      StWaitCcd,
      StPrea,
      StWaitRpa,
      StRef,
      StWaitRfc
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            running_q;

   logic            lat_wr_q, lat_wr_d;
   logic [3:0]      lat_bank_q, lat_bank_d;
   logic [13:0]     lat_row_q, lat_row_d;
   logic [9:0]      lat_col_q, lat_col_d;

   logic [15:0]     open_q, open_d;
   logic [13:0]     row_q [16];
   logic [13:0]     row_d [16];

   logic [4:0]      cmd_q, cmd_d;
   logic [13:0]     addr_q, addr_d;
   logic [3:0]      bank_q, bank_d;
   logic            ref_ack_q, ref_ack_d;
   logic            cas_pulse_q, cas_pulse_d;
   logic            cas_wr_q, cas_wr_d;

   logic [3:0]      req_bank;
   logic            any_open;

   assign req_bank  = {req_bg, req_ba};
   assign any_open  = |open_q;
   // running_q keeps req_ready low while reset is asserted
   assign req_ready = running_q && (state_q == StIdle) && !ref_req;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      lat_wr_d   = lat_wr_q;
      lat_bank_d = lat_bank_q;
      lat_row_d  = lat_row_q;
      lat_col_d  = lat_col_q;
      unique case (state_q)
         StIdle: begin
            if (ref_req) begin
               if (any_open) begin
                  state_d = StPrea;
                  cnt_d   = LdRp;
               end else begin
                  state_d = StRef;
                  cnt_d   = LdRfc;
               end
            end else if (req_valid && running_q) begin
               lat_wr_d   = req_wr;
               lat_bank_d = req_bank;
               lat_row_d  = req_row;
               lat_col_d  = req_col;
               if (!open_q[req_bank]) begin
                  state_d = StAct;
                  cnt_d   = LdRcd;
               end else if (row_q[req_bank] == req_row) begin
                  state_d = StCas;
                  cnt_d   = LdCcd;
               end else begin
                  state_d = StPre;
                  cnt_d   = LdRp;
               end
            end
         end
         // The counter holds T-1 during the command cycle, so the next command lands T cycles later.
         StPre, StWaitRp: begin
            if (cnt_q == '0) begin
               state_d = StAct;
               cnt_d   = LdRcd;
            end else begin
               state_d = StWaitRp;
               cnt_d   = cnt_q - 1'b1;
            end
         end
         StAct, StWaitRcd: begin
            if (cnt_q == '0) begin
               state_d = StCas;
               cnt_d   = LdCcd;
            end else begin
               state_d = StWaitRcd;
               cnt_d   = cnt_q - 1'b1;
            end
         end
         StCas, StWaitCcd: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               state_d = StWaitCcd;
               cnt_d   = cnt_q - 1'b1;
            end
         end
         StPrea, StWaitRpa: begin
            if (cnt_q == '0) begin
               state_d = StRef;
               cnt_d   = LdRfc;
            end else begin
               state_d = StWaitRpa;
               cnt_d   = cnt_q - 1'b1;
            end
         end
         StRef, StWaitRfc: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
            end else begin
               state_d = StWaitRfc;
               cnt_d   = cnt_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      open_d = open_q;
      row_d  = row_q;
      unique case (state_q)
         StAct: begin
            open_d[lat_bank_q] = 1'b1;
            row_d[lat_bank_q]  = lat_row_q;
         end
         StPre:   open_d[lat_bank_q] = 1'b0;
         StPrea:  open_d = '0;
         default: ;
      endcase
   end

   // Pins are registered from the next state so each command is glitch-free for one full cycle.
   always_comb begin
      cmd_d       = CmdDes;
      addr_d      = '0;
      bank_d      = '0;
      ref_ack_d   = 1'b0;
      cas_pulse_d = 1'b0;
      cas_wr_d    = 1'b0;
      unique case (state_d)
         StAct: begin
            cmd_d  = CmdAct;
            addr_d = lat_row_d;
            bank_d = lat_bank_d;
         end
         StCas: begin
            cmd_d       = lat_wr_d ? CmdWr : CmdRd;
            addr_d      = {1'b0, 1'b1, 1'b0, 1'b0, lat_col_d};
            bank_d      = lat_bank_d;
            cas_pulse_d = 1'b1;
            cas_wr_d    = lat_wr_d;
         end
         StPre: begin
            cmd_d  = CmdPre;
            bank_d = lat_bank_d;
         end
         StPrea: begin
            cmd_d      = CmdPre;
            addr_d[10] = 1'b1;
         end
         StRef: begin
            cmd_d     = CmdRef;
            ref_ack_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CK_t or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         running_q   <= 1'b0;
         lat_wr_q    <= 1'b0;
         lat_bank_q  <= '0;
         lat_row_q   <= '0;
         lat_col_q   <= '0;
         open_q      <= '0;
         cmd_q       <= CmdDes;
         addr_q      <= '0;
         bank_q      <= '0;
         ref_ack_q   <= 1'b0;
         cas_pulse_q <= 1'b0;
         cas_wr_q    <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            row_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         running_q   <= 1'b1;
         lat_wr_q    <= lat_wr_d;
         lat_bank_q  <= lat_bank_d;
         lat_row_q   <= lat_row_d;
         lat_col_q   <= lat_col_d;
         open_q      <= open_d;
         cmd_q       <= cmd_d;
         addr_q      <= addr_d;
         bank_q      <= bank_d;
         ref_ack_q   <= ref_ack_d;
         cas_pulse_q <= cas_pulse_d;
         cas_wr_q    <= cas_wr_d;
         for (int i = 0; i < 16; i++) begin
            row_q[i] <= row_d[i];
         end
      end
   end

   assign {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} = cmd_q;
   assign {A13, A12_BC_n, A11, A10_AP, A9_A0}          = addr_q;
   assign {bg_addr, ba_addr}                            = bank_q;
   assign ref_ack                                       = ref_ack_q;
   assign cas_pulse                                     = cas_pulse_q;
   assign cas_wr                                        = cas_wr_q;

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Directed bench for ddr_cmd_sequencer: command pin patterns and cycle timing for hit, closed,
// miss, refresh, refresh priority and mid-sequence reset.
module tb_ddr_cmd_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid, req_ready, req_wr;
   logic [1:0]  req_bg, req_ba;
   logic [13:0] req_row;
   logic [9:0]  req_col;
   logic        ref_req, ref_ack;
   logic        cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
   logic        A13, A12_BC_n, A11, A10_AP;
   logic [9:0]  A9_A0;
   logic [1:0]  bg_addr, ba_addr;
   logic        cas_pulse, cas_wr;

   logic [4:0]  cmd;
   logic [13:0] addr;
   assign cmd  = {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14};
   assign addr = {A13, A12_BC_n, A11, A10_AP, A9_A0};

   int checks   = 0;
   int failures = 0;

   logic [4:0]  cmd_tr  [0:40];
   logic [13:0] addr_tr [0:40];
   logic [1:0]  bg_tr   [0:40];
   logic [1:0]  ba_tr   [0:40];
   logic        cas_tr  [0:40];
   logic        casw_tr [0:40];
   logic        rdy_tr  [0:40];
   logic        ack_tr  [0:40];

   always #5 clk = ~clk;

   ddr_cmd_sequencer dut (
      .CK_t      (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_bg    (req_bg),
      .req_ba    (req_ba),
      .req_row   (req_row),
      .req_col   (req_col),
      .ref_req   (ref_req),
      .ref_ack   (ref_ack),
      .cs_n      (cs_n),
      .act_n     (act_n),
      .RAS_n_A16 (RAS_n_A16),
      .CAS_n_A15 (CAS_n_A15),
      .WE_n_A14  (WE_n_A14),
      .A13       (A13),
      .A12_BC_n  (A12_BC_n),
      .A11       (A11),
      .A10_AP    (A10_AP),
      .A9_A0     (A9_A0),
      .bg_addr   (bg_addr),
      .ba_addr   (ba_addr),
      .cas_pulse (cas_pulse),
      .cas_wr    (cas_wr)
   );

   // Records cycles 1..n (cycle 0 = the cycle whose closing edge may accept a request).
   task automatic capture(input int n, input bit acc_first);
      bit acc_prev;
      acc_prev = acc_first;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         cmd_tr[k]  = cmd;
         addr_tr[k] = addr;
         bg_tr[k]   = bg_addr;
         ba_tr[k]   = ba_addr;
         cas_tr[k]  = cas_pulse;
         casw_tr[k] = cas_wr;
         rdy_tr[k]  = req_ready;
         ack_tr[k]  = ref_ack;
         if (acc_prev) req_valid = 1'b0;
         acc_prev = req_valid && req_ready;
         if (ref_ack) ref_req = 1'b0;
      end
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) ok = 1'b1;
      end
   endtask

   task automatic issue(input bit wr, input logic [1:0] bg, input logic [1:0] ba,
                        input logic [13:0] row, input logic [9:0] col, output bit ok);
      wait_ready(ok);
      if (ok) begin
         req_valid = 1'b1;
         req_wr    = wr;
         req_bg    = bg;
         req_ba    = ba;
         req_row   = row;
         req_col   = col;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (cmd !== 5'b11111) begin
         failures++; $display("FAIL reset_cmd got=%b exp=11111", cmd);
      end
      checks++;
      if (addr !== 14'h0 || bg_addr !== 2'd0 || ba_addr !== 2'd0) begin
         failures++; $display("FAIL reset_addr got=%h/%0d/%0d exp=0/0/0", addr, bg_addr, ba_addr);
      end
      checks++;
      if (req_ready !== 1'b0 || ref_ack !== 1'b0 || cas_pulse !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags got rdy=%b ack=%b cas=%b exp=0", req_ready, ref_ack, cas_pulse);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++; $display("FAIL reset_ready_after got=%b exp=1", req_ready);
      end
   endtask

   task automatic test_closed_write();
      bit ok;
      issue(1'b1, 2'd1, 2'd2, 14'h1A5, 10'h040, ok);
      checks++;
      if (!ok) begin
         failures++; $display("FAIL closed_accept got=timeout exp=ready");
      end
      capture(9, 1'b1);
      checks++;
      if (cmd_tr[1] !== 5'b00111 || addr_tr[1] !== 14'h1A5) begin
         failures++; $display("FAIL closed_act got=%b/%h exp=00111/1a5", cmd_tr[1], addr_tr[1]);
      end
      checks++;
      if (bg_tr[1] !== 2'd1 || ba_tr[1] !== 2'd2) begin
         failures++; $display("FAIL closed_act_bank got=%0d/%0d exp=1/2", bg_tr[1], ba_tr[1]);
      end
      checks++;
      if (cmd_tr[4] !== 5'b11111 || cas_tr[4] !== 1'b0) begin
         failures++; $display("FAIL closed_wait got=%b/%b exp=11111/0", cmd_tr[4], cas_tr[4]);
      end
      checks++;
      if (cmd_tr[5] !== 5'b01100 || addr_tr[5] !== 14'h1040) begin
         failures++; $display("FAIL closed_wr got=%b/%h exp=01100/1040", cmd_tr[5], addr_tr[5]);
      end
      checks++;
      if (cas_tr[5] !== 1'b1 || casw_tr[5] !== 1'b1) begin
         failures++; $display("FAIL closed_cas_pulse got=%b/%b exp=1/1", cas_tr[5], casw_tr[5]);
      end
      checks++;
      if (rdy_tr[8] !== 1'b0 || rdy_tr[9] !== 1'b1) begin
         failures++; $display("FAIL closed_ready got=%b%b exp=01", rdy_tr[8], rdy_tr[9]);
      end
   endtask

   task automatic test_hit_read();
      bit ok;
      issue(1'b0, 2'd1, 2'd2, 14'h1A5, 10'h080, ok);
      checks++;
      if (!ok) begin
         failures++; $display("FAIL hit_accept got=timeout exp=ready");
      end
      capture(5, 1'b1);
      checks++;
      if (cmd_tr[1] !== 5'b01101 || addr_tr[1] !== 14'h1080) begin
         failures++; $display("FAIL hit_rd got=%b/%h exp=01101/1080", cmd_tr[1], addr_tr[1]);
      end
      checks++;
      if (cas_tr[1] !== 1'b1 || casw_tr[1] !== 1'b0 || bg_tr[1] !== 2'd1 || ba_tr[1] !== 2'd2) begin
         failures++;
         $display("FAIL hit_cas got=%b/%b/%0d/%0d exp=1/0/1/2", cas_tr[1], casw_tr[1],
                  bg_tr[1], ba_tr[1]);
      end
      checks++;
      if (rdy_tr[4] !== 1'b0 || rdy_tr[5] !== 1'b1) begin
         failures++; $display("FAIL hit_ready got=%b%b exp=01", rdy_tr[4], rdy_tr[5]);
      end
   endtask

   task automatic test_miss_read();
      bit ok;
      issue(1'b0, 2'd1, 2'd2, 14'h2B0, 10'h010, ok);
      checks++;
      if (!ok) begin
         failures++; $display("FAIL miss_accept got=timeout exp=ready");
      end
      capture(13, 1'b1);
      checks++;
      if (cmd_tr[1] !== 5'b01010 || addr_tr[1][10] !== 1'b0 || bg_tr[1] !== 2'd1
          || ba_tr[1] !== 2'd2) begin
         failures++;
         $display("FAIL miss_pre got=%b/a10=%b/%0d/%0d exp=01010/0/1/2", cmd_tr[1], addr_tr[1][10],
                  bg_tr[1], ba_tr[1]);
      end
      checks++;
      if (cmd_tr[5] !== 5'b00111 || addr_tr[5] !== 14'h2B0) begin
         failures++; $display("FAIL miss_act got=%b/%h exp=00111/2b0", cmd_tr[5], addr_tr[5]);
      end
      checks++;
      if (cmd_tr[9] !== 5'b01101 || addr_tr[9] !== 14'h1010 || cas_tr[9] !== 1'b1) begin
         failures++;
         $display("FAIL miss_rd got=%b/%h/%b exp=01101/1010/1", cmd_tr[9], addr_tr[9], cas_tr[9]);
      end
      checks++;
      if (rdy_tr[12] !== 1'b0 || rdy_tr[13] !== 1'b1) begin
         failures++; $display("FAIL miss_ready got=%b%b exp=01", rdy_tr[12], rdy_tr[13]);
      end
   endtask

   task automatic test_refresh();
      bit ok;
      // open a second bank (bg0/ba0) alongside bg1/ba2
      issue(1'b1, 2'd0, 2'd0, 14'h0005, 10'h001, ok);
      capture(9, 1'b1);
      wait_ready(ok);
      checks++;
      if (!ok) begin
         failures++; $display("FAIL ref_idle got=timeout exp=ready");
      end
      ref_req = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         failures++; $display("FAIL ref_blocks_ready got=%b exp=0", req_ready);
      end
      capture(25, 1'b0);
      checks++;
      if (cmd_tr[1] !== 5'b01010 || addr_tr[1] !== 14'h0400) begin
         failures++; $display("FAIL ref_prea got=%b/%h exp=01010/0400", cmd_tr[1], addr_tr[1]);
      end
      checks++;
      if (cmd_tr[4] !== 5'b11111 || ack_tr[4] !== 1'b0) begin
         failures++; $display("FAIL ref_wait_rp got=%b/%b exp=11111/0", cmd_tr[4], ack_tr[4]);
      end
      checks++;
      if (cmd_tr[5] !== 5'b01001 || ack_tr[5] !== 1'b1) begin
         failures++; $display("FAIL ref_ref got=%b/%b exp=01001/1", cmd_tr[5], ack_tr[5]);
      end
      checks++;
      if (ack_tr[6] !== 1'b0) begin
         failures++; $display("FAIL ref_ack_pulse got=%b exp=0", ack_tr[6]);
      end
      checks++;
      if (rdy_tr[24] !== 1'b0 || rdy_tr[25] !== 1'b1) begin
         failures++; $display("FAIL ref_ready got=%b%b exp=01", rdy_tr[24], rdy_tr[25]);
      end
      // bg1/ba2 row 0x2B0 was open; after PREA it must be activated again
      issue(1'b0, 2'd1, 2'd2, 14'h2B0, 10'h000, ok);
      capture(9, 1'b1);
      checks++;
      if (cmd_tr[1] !== 5'b00111 || addr_tr[1] !== 14'h2B0) begin
         failures++; $display("FAIL ref_banks_closed got=%b/%h exp=00111/2b0", cmd_tr[1], addr_tr[1]);
      end
   endtask

   task automatic test_ref_priority();
      bit ok;
      // issue PREA first so every bank is closed and REF goes out directly
      wait_ready(ok);
      ref_req = 1'b1;
      capture(30, 1'b0);
      wait_ready(ok);
      ref_req   = 1'b1;
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_bg    = 2'd3;
      req_ba    = 2'd3;
      req_row   = 14'h3FF;
      req_col   = 10'h003;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         failures++; $display("FAIL prio_ready got=%b exp=0", req_ready);
      end
      capture(26, 1'b0);
      checks++;
      if (cmd_tr[1] !== 5'b01001 || ack_tr[1] !== 1'b1) begin
         failures++; $display("FAIL prio_ref_first got=%b/%b exp=01001/1", cmd_tr[1], ack_tr[1]);
      end
      checks++;
      if (rdy_tr[20] !== 1'b0 || rdy_tr[21] !== 1'b1 || cmd_tr[21] !== 5'b11111) begin
         failures++;
         $display("FAIL prio_rfc got=%b%b/%b exp=01/11111", rdy_tr[20], rdy_tr[21], cmd_tr[21]);
      end
      checks++;
      if (cmd_tr[22] !== 5'b00111 || addr_tr[22] !== 14'h3FF || bg_tr[22] !== 2'd3
          || ba_tr[22] !== 2'd3) begin
         failures++;
         $display("FAIL prio_act got=%b/%h/%0d/%0d exp=00111/3ff/3/3", cmd_tr[22], addr_tr[22],
                  bg_tr[22], ba_tr[22]);
      end
      checks++;
      if (cmd_tr[26] !== 5'b01100 || addr_tr[26] !== 14'h1003 || casw_tr[26] !== 1'b1) begin
         failures++;
         $display("FAIL prio_wr got=%b/%h/%b exp=01100/1003/1", cmd_tr[26], addr_tr[26], casw_tr[26]);
      end
   endtask

   task automatic test_reset_midseq();
      bit ok;
      capture(4, 1'b0);
      issue(1'b1, 2'd2, 2'd1, 14'h00AA, 10'h00F, ok);
      capture(3, 1'b1);
      checks++;
      if (cmd_tr[1] !== 5'b00111) begin
         failures++; $display("FAIL midrst_act got=%b exp=00111", cmd_tr[1]);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (cmd !== 5'b11111 || req_ready !== 1'b0) begin
         failures++; $display("FAIL midrst_now got=%b/%b exp=11111/0", cmd, req_ready);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (cmd !== 5'b11111 || cas_pulse !== 1'b0) begin
         failures++; $display("FAIL midrst_no_cas got=%b/%b exp=11111/0", cmd, cas_pulse);
      end
      reset_n = 1'b1;
      issue(1'b1, 2'd2, 2'd1, 14'h00AA, 10'h00F, ok);
      capture(9, 1'b1);
      checks++;
      if (cmd_tr[1] !== 5'b00111 || addr_tr[1] !== 14'h00AA || cmd_tr[5] !== 5'b01100) begin
         failures++;
         $display("FAIL midrst_reissue got=%b/%h/%b exp=00111/0aa/01100", cmd_tr[1], addr_tr[1],
                  cmd_tr[5]);
      end
      // bg3/ba3 row 0x3FF was open before reset; the table must have been cleared
      issue(1'b0, 2'd3, 2'd3, 14'h3FF, 10'h004, ok);
      capture(9, 1'b1);
      checks++;
      if (cmd_tr[1] !== 5'b00111 || cmd_tr[5] !== 5'b01101) begin
         failures++; $display("FAIL midrst_table got=%b/%b exp=00111/01101", cmd_tr[1], cmd_tr[5]);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_bg    = 2'd0;
      req_ba    = 2'd0;
      req_row   = 14'h0;
      req_col   = 10'h0;
      ref_req   = 1'b0;
      test_reset();
      test_closed_write();
      test_hit_read();
      test_miss_read();
      test_refresh();
      test_ref_priority();
      test_reset_midseq();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
